// File: rtl/pwm_deadtime_gen.sv
// pwm_deadtime_gen: tick-driven PWM with double-buffered duty and
// complementary high/low outputs separated by a programmable dead-time.
//
// Ports:
//   clk, reset_n      system clock, async active-low reset
//   enable            block enable; low forces both outputs off next cycle
//   tick              counter advance strobe (from the periodic timer)
//   duty_in/valid     new duty value offered on a valid/ready handshake
//   duty_ready        shadow register free (no duty update pending)
//   dead_time         gap in clk cycles between one side off and the other on
//   pwm_h, pwm_l      high-side / low-side drive, never both high
//   period_end        one-cycle pulse after the counter wraps
module pwm_deadtime_gen #(
    parameter int unsigned R       = 8,
    parameter int unsigned DT_BITS = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               tick,
    input  logic [R-1:0]       duty_in,
    input  logic               duty_valid,
    output logic               duty_ready,
    input  logic [DT_BITS-1:0] dead_time,
    output logic               pwm_h,
    output logic               pwm_l,
    output logic               period_end
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        H_ON = 2'd1,
        L_ON = 2'd2,
        DEAD = 2'd3
    } state_t;

    logic [R-1:0]       cnt;
    logic [R-1:0]       duty_act;
    logic [R-1:0]       duty_sh;
    logic               wrap_c;
    logic               raw_c;

    state_t             state_q, state_d;
    logic               tgt_q, tgt_d;         // 1: heading to H_ON, 0: heading to L_ON
    logic [DT_BITS-1:0] dt_cnt_q, dt_cnt_d;
    logic               switch_c;

    assign wrap_c = enable && tick && (cnt == {R{1'b1}});
    assign raw_c  = (cnt < duty_act);

    // Period counter; holds while disabled or between ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (enable && tick) begin
            cnt <= cnt + R'(1);
        end
    end

    // Duty shadow: duty_ready doubles as the inverted pending flag. A transfer
    // needs ready=1 and an apply needs ready=0, so they never collide; a value
    // accepted on a wrap cycle therefore waits for the following wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_sh    <= '0;
            duty_act   <= '0;
            duty_ready <= 1'b1;
        end else if (duty_valid && duty_ready) begin
            duty_sh    <= duty_in;
            duty_ready <= 1'b0;
        end else if (wrap_c && !duty_ready) begin
            duty_act   <= duty_sh;
            duty_ready <= 1'b1;
        end
    end

    // Period boundary pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_end <= 1'b0;
        end else begin
            period_end <= wrap_c;
        end
    end

    // Output FSM state register; outputs are the registered decode of the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            tgt_q    <= 1'b0;
            dt_cnt_q <= '0;
            pwm_h    <= 1'b0;
            pwm_l    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            dt_cnt_q <= dt_cnt_d;
            pwm_h    <= (state_d == H_ON);
            pwm_l    <= (state_d == L_ON);
        end
    end

    // Next-state logic; switch_c requests a move toward the side raw selects.
    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        dt_cnt_d = dt_cnt_q;
        switch_c = 1'b0;

        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: switch_c = 1'b1;
                H_ON: switch_c = !raw_c;
                L_ON: switch_c = raw_c;
                DEAD: begin
                    if (raw_c != tgt_q) begin
                        // Target flipped mid-gap: restart the gap toward the new side.
                        switch_c = 1'b1;
                    end else if (dt_cnt_q <= DT_BITS'(1)) begin
                        state_d = tgt_q ? H_ON : L_ON;
                    end else begin
                        dt_cnt_d = dt_cnt_q - DT_BITS'(1);
                    end
                end
                default: state_d = IDLE;
            endcase

            if (switch_c) begin
                if (dead_time == '0) begin
                    state_d = raw_c ? H_ON : L_ON;
                end else begin
                    state_d  = DEAD;
                    tgt_d    = raw_c;
                    dt_cnt_d = dead_time;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench for pwm_deadtime_gen with R=4 (16-tick period).
module tb_pwm_deadtime_gen;

    localparam int unsigned R       = 4;
    localparam int unsigned DT_BITS = 4;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               enable;
    logic               tick;
    logic [R-1:0]       duty_in;
    logic               duty_valid;
    logic               duty_ready;
    logic [DT_BITS-1:0] dead_time;
    logic               pwm_h;
    logic               pwm_l;
    logic               period_end;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit slow  = 1'b0;

    always #5 clk = ~clk;

    pwm_deadtime_gen #(.R(R), .DT_BITS(DT_BITS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .tick       (tick),
        .duty_in    (duty_in),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .dead_time  (dead_time),
        .pwm_h      (pwm_h),
        .pwm_l      (pwm_l),
        .period_end (period_end)
    );

    // Advance one clk, sample point 1 time unit after the edge; tick for the
    // next edge is set here (every 5th clk in slow mode).
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        tick = slow ? ((cyc % 5) == 0) : 1'b1;
    endtask

    task automatic wait_pe(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (period_end === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Gathers output statistics over len samples; gaps are runs of both-low
    // that end when one side turns on.
    task automatic measure(input int len, output int nh, output int nl, output int npe,
                           output int novl, output int gmin, output int gmax, output int pel);
        int run;
        nh = 0; nl = 0; npe = 0; novl = 0; gmin = 999; gmax = 0; pel = -1; run = 0;
        for (int i = 0; i < len; i++) begin
            step();
            if (pwm_h === 1'b1 && pwm_l === 1'b1) novl++;
            if (pwm_h === 1'b1) nh++;
            if (pwm_l === 1'b1) nl++;
            if (period_end === 1'b1) begin
                npe++;
                pel = i;
            end
            if (pwm_h !== 1'b1 && pwm_l !== 1'b1) begin
                run++;
            end else begin
                if (run > 0) begin
                    if (run < gmin) gmin = run;
                    if (run > gmax) gmax = run;
                end
                run = 0;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; tick = 1'b1; duty_in = '0;
        duty_valid = 1'b0; dead_time = '0;
        repeat (3) step();
        n_vec++; if (pwm_h !== 1'b0) begin n_bad++; $display("FAIL reset_pwm_h: got %b want 0", pwm_h); end
        n_vec++; if (pwm_l !== 1'b0) begin n_bad++; $display("FAIL reset_pwm_l: got %b want 0", pwm_l); end
        n_vec++; if (period_end !== 1'b0) begin n_bad++; $display("FAIL reset_period_end: got %b want 0", period_end); end
        n_vec++; if (duty_ready !== 1'b1) begin n_bad++; $display("FAIL reset_duty_ready: got %b want 1", duty_ready); end
        #4;
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int n, nh, nl, npe, novl, gmin, gmax, pel;
        dead_time = 4'd0; enable = 1'b1; duty_in = 4'd4; duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        n_vec++; if (duty_ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready_drop: got %b want 0", duty_ready); end
        n_vec++; if (pwm_l !== 1'b1 || pwm_h !== 1'b0) begin n_bad++; $display("FAIL basic_first_l: got h=%b l=%b want h=0 l=1", pwm_h, pwm_l); end
        n = 0;
        while (duty_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        n_vec++; if (n !== 15) begin n_bad++; $display("FAIL basic_ready_low_cycles: got %0d want 15", n); end
        n_vec++; if (period_end !== 1'b1) begin n_bad++; $display("FAIL basic_wrap_pe: got %b want 1", period_end); end
        repeat (2) begin
            measure(16, nh, nl, npe, novl, gmin, gmax, pel);
            n_vec++; if (nh !== 4) begin n_bad++; $display("FAIL basic_h_count: got %0d want 4", nh); end
            n_vec++; if (nl !== 12) begin n_bad++; $display("FAIL basic_l_count: got %0d want 12", nl); end
            n_vec++; if (npe !== 1 || pel !== 15) begin n_bad++; $display("FAIL basic_pe_period: got n=%0d at %0d want 1 at 15", npe, pel); end
            n_vec++; if (novl !== 0) begin n_bad++; $display("FAIL basic_overlap: got %0d want 0", novl); end
        end
    endtask

    task automatic test_deadtime();
        int nh, nl, npe, novl, gmin, gmax, pel;
        bit ok;
        dead_time = 4'd3; duty_in = 4'd8; duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        n_vec++; if (duty_ready !== 1'b0) begin n_bad++; $display("FAIL dt_write_accept: got %b want 0", duty_ready); end
        repeat (2) begin
            wait_pe(40, ok);
            n_vec++; if (!ok) begin n_bad++; $display("FAIL dt_wait_wrap: got timeout want period_end"); end
        end
        measure(16, nh, nl, npe, novl, gmin, gmax, pel);
        n_vec++; if (nh !== 5) begin n_bad++; $display("FAIL dt_h_count: got %0d want 5", nh); end
        n_vec++; if (nl !== 5) begin n_bad++; $display("FAIL dt_l_count: got %0d want 5", nl); end
        n_vec++; if (gmin !== 3 || gmax !== 3) begin n_bad++; $display("FAIL dt_gap_len: got min=%0d max=%0d want 3", gmin, gmax); end
        n_vec++; if (novl !== 0) begin n_bad++; $display("FAIL dt_overlap: got %0d want 0", novl); end
    endtask

    task automatic test_boundaries();
        int nh, nl, npe, novl, gmin, gmax, pel;
        bit ok;
        dead_time = 4'd0; duty_in = 4'd0; duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        repeat (2) begin
            wait_pe(40, ok);
            n_vec++; if (!ok) begin n_bad++; $display("FAIL bnd0_wait_wrap: got timeout want period_end"); end
        end
        measure(16, nh, nl, npe, novl, gmin, gmax, pel);
        n_vec++; if (nh !== 0) begin n_bad++; $display("FAIL bnd0_h_count: got %0d want 0", nh); end
        n_vec++; if (nl !== 16) begin n_bad++; $display("FAIL bnd0_l_count: got %0d want 16", nl); end

        duty_in = 4'd15; duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        repeat (2) begin
            wait_pe(40, ok);
            n_vec++; if (!ok) begin n_bad++; $display("FAIL bnd15_wait_wrap: got timeout want period_end"); end
        end
        measure(16, nh, nl, npe, novl, gmin, gmax, pel);
        n_vec++; if (nh !== 15) begin n_bad++; $display("FAIL bnd15_h_count: got %0d want 15", nh); end
        n_vec++; if (nl !== 1) begin n_bad++; $display("FAIL bnd15_l_count: got %0d want 1", nl); end
        n_vec++; if (npe !== 1 || pel !== 15) begin n_bad++; $display("FAIL bnd15_wrap: got n=%0d at %0d want 1 at 15", npe, pel); end
    endtask

    task automatic test_shadow();
        int nh, nl, npe, novl, gmin, gmax, pel;
        bit ok;
        wait_pe(40, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL sh_wait_wrap: got timeout want period_end"); end
        repeat (15) step();
        duty_in = 4'd2; duty_valid = 1'b1;
        step();
        n_vec++; if (period_end !== 1'b1) begin n_bad++; $display("FAIL sh_concurrent_wrap: got %b want 1", period_end); end
        n_vec++; if (duty_ready !== 1'b0) begin n_bad++; $display("FAIL sh_first_accept: got %b want 0", duty_ready); end
        duty_in = 4'd9;
        nh = 0; nl = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (pwm_h === 1'b1) nh++;
            if (pwm_l === 1'b1) nl++;
            if (i < 15) begin
                n_vec++; if (duty_ready !== 1'b0) begin n_bad++; $display("FAIL sh_stall_%0d: got ready=%b want 0", i, duty_ready); end
            end
            if (i == 14) duty_valid = 1'b0;
        end
        n_vec++; if (period_end !== 1'b1 || duty_ready !== 1'b1) begin n_bad++; $display("FAIL sh_apply_wrap: got pe=%b ready=%b want 1 1", period_end, duty_ready); end
        n_vec++; if (nh !== 15 || nl !== 1) begin n_bad++; $display("FAIL sh_old_duty: got h=%0d l=%0d want 15 1", nh, nl); end
        measure(16, nh, nl, npe, novl, gmin, gmax, pel);
        n_vec++; if (nh !== 2 || nl !== 14) begin n_bad++; $display("FAIL sh_new_duty: got h=%0d l=%0d want 2 14", nh, nl); end
    endtask

    task automatic test_slow_tick();
        int nh, nl, npe, novl, gmin, gmax, pel;
        bit ok;
        slow = 1'b1; dead_time = 4'd2; duty_in = 4'd8; duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        repeat (2) begin
            wait_pe(200, ok);
            n_vec++; if (!ok) begin n_bad++; $display("FAIL slow_wait_wrap: got timeout want period_end"); end
        end
        measure(80, nh, nl, npe, novl, gmin, gmax, pel);
        n_vec++; if (npe !== 1 || pel !== 79) begin n_bad++; $display("FAIL slow_period: got n=%0d at %0d want 1 at 79", npe, pel); end
        n_vec++; if (nh !== 38 || nl !== 38) begin n_bad++; $display("FAIL slow_hl_count: got h=%0d l=%0d want 38 38", nh, nl); end
        n_vec++; if (gmin !== 2 || gmax !== 2) begin n_bad++; $display("FAIL slow_gap_len: got min=%0d max=%0d want 2", gmin, gmax); end
        n_vec++; if (novl !== 0) begin n_bad++; $display("FAIL slow_overlap: got %0d want 0", novl); end
    endtask

    task automatic test_disturb();
        int nh, nl, npe, novl, gmin, gmax, pel;
        bit ok;
        slow = 1'b0; tick = 1'b1; dead_time = 4'd3;
        repeat (2) begin
            wait_pe(200, ok);
            n_vec++; if (!ok) begin n_bad++; $display("FAIL dis_wait_wrap: got timeout want period_end"); end
        end
        repeat (4) step();
        n_vec++; if (pwm_h !== 1'b1) begin n_bad++; $display("FAIL dis_in_h_on: got %b want 1", pwm_h); end
        enable = 1'b0;
        step();
        n_vec++; if (pwm_h !== 1'b0 || pwm_l !== 1'b0) begin n_bad++; $display("FAIL dis_off_next: got h=%b l=%b want 0 0", pwm_h, pwm_l); end
        for (int i = 0; i < 20; i++) begin
            step();
            n_vec++; if (pwm_h !== 1'b0 || pwm_l !== 1'b0 || period_end !== 1'b0) begin
                n_bad++; $display("FAIL dis_idle_%0d: got h=%b l=%b pe=%b want 0 0 0", i, pwm_h, pwm_l, period_end);
            end
        end
        enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_vec++; if (pwm_h !== 1'b0 || pwm_l !== 1'b0) begin n_bad++; $display("FAIL dis_reen_dead_%0d: got h=%b l=%b want 0 0", i, pwm_h, pwm_l); end
        end
        step();
        n_vec++; if (pwm_h !== 1'b1) begin n_bad++; $display("FAIL dis_reen_h: got %b want 1", pwm_h); end
        duty_in = 4'd3; duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        n_vec++; if (pwm_h !== 1'b0 || pwm_l !== 1'b0) begin n_bad++; $display("FAIL dis_cnt_resumed: got h=%b l=%b want 0 0", pwm_h, pwm_l); end
        n_vec++; if (duty_ready !== 1'b0) begin n_bad++; $display("FAIL dis_pending: got %b want 0", duty_ready); end
        step();
        reset_n = 1'b0;
        #2;
        n_vec++; if (pwm_h !== 1'b0 || pwm_l !== 1'b0) begin n_bad++; $display("FAIL dis_rst_out: got h=%b l=%b want 0 0", pwm_h, pwm_l); end
        n_vec++; if (duty_ready !== 1'b1) begin n_bad++; $display("FAIL dis_rst_ready: got %b want 1", duty_ready); end
        #2;
        reset_n = 1'b1;
        repeat (2) begin
            wait_pe(40, ok);
            n_vec++; if (!ok) begin n_bad++; $display("FAIL dis_post_rst_wrap: got timeout want period_end"); end
        end
        measure(16, nh, nl, npe, novl, gmin, gmax, pel);
        n_vec++; if (nh !== 0 || nl !== 16) begin n_bad++; $display("FAIL dis_shadow_dropped: got h=%0d l=%0d want 0 16", nh, nl); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_deadtime();
        test_boundaries();
        test_shadow();
        test_slow_tick();
        test_disturb();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
